// File: rtl/serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl_if
// Request/result bundle for the bit-serial adder controller.
//   start        request strobe (sampled by the controller only in IDLE/DONE)
//   op_a, op_b   WIDTH-bit operands, captured on an accepted start
//   cin          carry-in, captured on an accepted start
//   busy         high while the controller is shifting bits through the adder
//   done         one-cycle pulse, result valid
//   sum, cout    registered result, held until the next completion
//   ovf          signed overflow flag (only when SERIAL_ADD_OVF_EN is defined)
// Modports: master = requester side, slave = controller side.
// Optional feature macro: SERIAL_ADD_OVF_EN
// -----------------------------------------------------------------------------
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, sum, cout, ovf
    );
`else
    modport master (
        output start, op_a, op_b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, op_a, op_b, cin,
        output busy, done, sum, cout
    );
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// serial_adder_ctrl
// Bit-serial adder controller. Captures two WIDTH-bit operands and a carry-in,
// feeds them LSB-first through one 1-bit full-adder cell, re-accumulates the
// sum bits and returns {cout, sum} = op_a + op_b + cin after WIDTH cycles.
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    serial_adder_ctrl_if.slave
//            start/op_a/op_b/cin in, busy/done/sum/cout out
//            (+ ovf out when SERIAL_ADD_OVF_EN is defined)
//
// Timing: start sampled at edge k -> bits processed at edges k+1..k+WIDTH ->
// done high for the cycle after edge k+WIDTH. busy is high exactly in SHIFT.
//
// Optional feature macro: SERIAL_ADD_OVF_EN
//   defined   : ovf = signed two's-complement overflow, registered with sum.
//   undefined : no ovf port or logic.
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_adder_ctrl_if.slave bus
);

    localparam int                CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // 1-bit full-adder cell; returns {carry_out, sum_bit}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
        return {co, s};
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] s_sh_q, s_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic [1:0]       fa_out;
    logic [WIDTH-1:0] s_next;

    // Full-adder cell inputs always come from the LSBs of the shift registers
    // and the running carry; only SHIFT consumes the result.
    always_comb begin
        fa_out = full_add(a_sh_q[0], b_sh_q[0], carry_q);
        s_next = {fa_out[0], s_sh_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        s_sh_d  = s_sh_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    a_sh_d  = bus.op_a;
                    b_sh_d  = bus.op_b;
                    carry_d = bus.cin;
                    count_d = '0;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_SHIFT: begin
                carry_d = fa_out[1];
                s_sh_d  = s_next;
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                if (count_q == CNT_LAST) begin
                    // Last bit: publish the result. The counter is parked at
                    // zero so it never reaches WIDTH.
                    count_d = '0;
                    sum_d   = s_next;
                    cout_d  = fa_out[1];
`ifdef SERIAL_ADD_OVF_EN
                    // carry_q here is the carry into the MSB.
                    ovf_d   = carry_q ^ fa_out[1];
`endif
                    state_d = ST_DONE;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            s_sh_q  <= s_sh_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = (state_q == ST_DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_adder_ctrl
// Self-checking bench for serial_adder_ctrl (WIDTH=8). Expected results come
// from plain integer arithmetic on the captured operands; timing expectations
// (WIDTH busy cycles, single done cycle, held results) come from the
// controller's documented behaviour.
// Optional feature macro: SERIAL_ADD_OVF_EN (adds ovf checks).
// -----------------------------------------------------------------------------
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] last_sum;
    logic         last_cout;
    logic         last_ovf;

    serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_byte(output logic [W-1:0] v);
        int unsigned r;
        r = $urandom;
        v = r[W-1:0];
    endtask

    task automatic check_held(input string tag);
        check_eq({tag, "_sum_held"}, 32'(bus.sum), 32'(last_sum));
        check_eq({tag, "_cout_held"}, 32'(bus.cout), 32'(last_cout));
`ifdef SERIAL_ADD_OVF_EN
        check_eq({tag, "_ovf_held"}, 32'(bus.ovf), 32'(last_ovf));
`endif
    endtask

    // Called just after a falling edge with the controller in IDLE or DONE.
    // Returns just after the falling edge at which done is observed.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit mid_start);
        logic [W:0]   exp_full;
        int           sa, sb, ssum;
        logic         exp_ovf;
        int           cyc;
        logic [W-1:0] junk;

        exp_full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        sa       = int'($signed(a));
        sb       = int'($signed(b));
        ssum     = sa + sb + int'(c);
        exp_ovf  = (ssum > 127) || (ssum < -128);

        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
        @(negedge clk);
        bus.start = 1'b0;
        // Scramble inputs after capture; they must not disturb the operation.
        rand_byte(junk); bus.op_a = junk;
        rand_byte(junk); bus.op_b = junk;
        bus.cin = ~c;

        check_eq({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
        cyc = 0;
        while (bus.busy && cyc < 40) begin
            check_eq({tag, "_done_in_shift"}, 32'(bus.done), 32'd0);
            check_held(tag);
            if (mid_start && cyc == 3) begin
                bus.start = 1'b1;
                rand_byte(junk); bus.op_a = junk;
                rand_byte(junk); bus.op_b = junk;
            end else begin
                bus.start = 1'b0;
            end
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check_eq({tag, "_busy_cycles"}, 32'(cyc), 32'(W));
        check_eq({tag, "_done"}, 32'(bus.done), 32'd1);
        check_eq({tag, "_sum"}, 32'(bus.sum), 32'(exp_full[W-1:0]));
        check_eq({tag, "_cout"}, 32'(bus.cout), 32'(exp_full[W]));
`ifdef SERIAL_ADD_OVF_EN
        check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`endif
        last_sum  = exp_full[W-1:0];
        last_cout = exp_full[W];
        last_ovf  = exp_ovf;
    endtask

    // One cycle after a done with no new start: back to IDLE.
    task automatic settle(input string tag);
        @(negedge clk);
        check_eq({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check_held(tag);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check_eq({tag, "_done"}, 32'(bus.done), 32'd0);
        check_eq({tag, "_sum"}, 32'(bus.sum), 32'd0);
        check_eq({tag, "_cout"}, 32'(bus.cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        check_eq({tag, "_ovf"}, 32'(bus.ovf), 32'd0);
`endif
    endtask

    initial begin
        logic [W-1:0] ra, rb, rj;
        int unsigned  r;

        bus.start = 1'b0;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.cin   = 1'b0;
        last_sum  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_vals("reset");
        repeat (2) @(negedge clk);
        check_reset_vals("reset_hold");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op("t1", 8'h0F, 8'h01, 1'b0, 1'b0); settle("t1");
        run_op("t2a", 8'hFF, 8'h01, 1'b0, 1'b0); settle("t2a");
        run_op("t2b", 8'hFF, 8'hFF, 1'b1, 1'b0); settle("t2b");
        run_op("t2c", 8'h00, 8'h00, 1'b0, 1'b0); settle("t2c");

        // Back-to-back: new start issued in the DONE cycle
        run_op("t3a", 8'h0F, 8'h01, 1'b0, 1'b0);
        run_op("t3b", 8'h12, 8'h34, 1'b0, 1'b0); settle("t3b");

        // start during SHIFT is ignored
        run_op("t4", 8'h21, 8'h43, 1'b1, 1'b1); settle("t4");

        // Overflow patterns (sum/cout always checked; ovf when enabled)
        run_op("t6a", 8'h7F, 8'h01, 1'b0, 1'b0); settle("t6a");
        run_op("t6b", 8'h80, 8'h80, 1'b0, 1'b0); settle("t6b");
        run_op("t6c", 8'h40, 8'h30, 1'b0, 1'b0); settle("t6c");

        // Reset mid-SHIFT
        bus.start = 1'b1;
        bus.op_a  = 8'hAA;
        bus.op_b  = 8'h55;
        bus.cin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t5_busy_before", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("t5_abort");
        @(negedge clk);
        rst_n = 1'b1;
        last_sum  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        @(negedge clk);
        check_reset_vals("t5_after");
        run_op("t5_new", 8'h3C, 8'h0D, 1'b1, 1'b0); settle("t5_new");

        // Randomized operations, mixing back-to-back starts and ignored starts
        for (int i = 0; i < 1000; i++) begin
            rand_byte(ra);
            rand_byte(rb);
            r = $urandom;
            run_op("rnd", ra, rb, r[0], (r[3:2] == 2'b00));
            if (r[1]) begin
                settle("rnd");
                if (r[4]) begin
                    rand_byte(rj);
                    bus.op_a = rj;
                    @(negedge clk);
                    check_eq("rnd_idle_stay", 32'(bus.busy), 32'd0);
                end
            end
        end
        settle("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
